// File: rtl/iter_divider_16.sv
// Restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to add two's-complement division selected by sign_op.
module iter_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign_op,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             ovfl
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovp_q, ovp_d;
    logic ovfl_q, ovfl_d;
    logic a_neg, b_neg, ovf_in;

    assign a_neg   = sign_op & dividend[WIDTH-1];
    assign b_neg   = sign_op & divisor[WIDTH-1];
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor : divisor;
    // MIN / -1 needs no special datapath: |MIN|/1 negated wraps back to MIN
    assign ovf_in  = sign_op
                   && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                   && (&divisor);
    assign quo_fix = qneg_q ? -quo_nxt : quo_nxt;
    assign rem_fix = rneg_q ? -rem_nxt : rem_nxt;
    assign ovfl    = ovfl_q;
`else
    logic unused_sign;

    assign unused_sign = sign_op;
    assign a_mag       = dividend;
    assign b_mag       = divisor;
    assign quo_fix     = quo_nxt;
    assign rem_fix     = rem_nxt;
    assign ovfl        = 1'b0;
`endif

    // Partial remainder stays below the divisor, so WIDTH+2 bits never wrap
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dsr_q};
    assign borrow  = diff[WIDTH+1];
    assign rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nxt = {dvd_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quot_d  = quot_q;
        rout_d  = rout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovp_d   = ovp_q;
        ovfl_d  = ovfl_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
                    ovfl_d = 1'b0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    ovp_d  = ovf_in;
`endif
                    if (divisor == '0) begin
                        dvd_d   = dividend;
                        dsr_d   = '0;
                        quot_d  = '1;
                        rout_d  = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        dvd_d   = a_mag;
                        dsr_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nxt;
                dvd_d = quo_nxt;
                cnt_d = cnt_q - CW'(1);
                // Last bit: publish results so done lands in the FINISH cycle
                if (cnt_q == CW'(1)) begin
                    quot_d  = quo_fix;
                    rout_d  = rem_fix;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
`ifdef DIV_SIGNED_EN
                    ovfl_d  = ovp_q;
`endif
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quot_q  <= '0;
            rout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovp_q   <= 1'b0;
            ovfl_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quot_q  <= quot_d;
            rout_q  <= rout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovp_q   <= ovp_d;
            ovfl_q  <= ovfl_d;
`endif
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider_16.sv
// Directed + scoreboard bench for iter_divider_16 (latency, results, flags).
module tb_iter_divider_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        sign_op;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        ovfl;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    iter_divider_16 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .sign_op    (sign_op),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .ovfl       (ovfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic sop,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edbz, input logic eov,
                          input int lat, input int inj);
        exp_t e;
        int   cyc;
        int   bcyc;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sign_op  = sop;
        start    = 1'b1;
        e.q = eq; e.r = er; e.dbz = edbz; e.ov = eov;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        cyc  = 1;
        bcyc = 0;
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            if (cyc == inj) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 16'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy_cycles"}, bcyc, lat - 1);
        e = sb.pop_front();
        chk({tag, " quotient"}, quotient, e.q);
        chk({tag, " remainder"}, remainder, e.r);
        chk({tag, " div_by_zero"}, div_by_zero, e.dbz);
        chk({tag, " ovfl"}, ovfl, e.ov);
        @(posedge clk);
        #1;
        chk({tag, " done_width"}, done, 1'b0);
        chk({tag, " idle_busy"}, busy, 1'b0);
        chk({tag, " held_q"}, quotient, e.q);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        sign_op  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset quotient", quotient, 16'h0);
        chk("reset remainder", remainder, 16'h0);
        chk("reset dbz", div_by_zero, 1'b0);
        chk("reset ovfl", ovfl, 1'b0);

        run_op("100/7", 16'd100, 16'd7, 1'b0,
               16'h000E, 16'h0002, 1'b0, 1'b0, 17, 0);
        run_op("dbz", 16'h1234, 16'h0000, 1'b0,
               16'hFFFF, 16'h1234, 1'b1, 1'b0, 1, 0);
        run_op("ffff/1", 16'hFFFF, 16'h0001, 1'b0,
               16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 0);
        run_op("50/5 ignore", 16'd50, 16'd5, 1'b0,
               16'd10, 16'd0, 1'b0, 1'b0, 17, 5);
        run_op("7/ffff", 16'd7, 16'hFFFF, 1'b0,
               16'd0, 16'd7, 1'b0, 1'b0, 17, 0);

        // Abort mid-operation with rst
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort quotient", quotient, 16'h0);
        chk("abort remainder", remainder, 16'h0);
        begin
            int seen = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (done || busy) seen++;
            end
            chk("abort no_done", seen, 0);
        end
        run_op("1000/3", 16'd1000, 16'd3, 1'b0,
               16'd333, 16'd1, 1'b0, 1'b0, 17, 0);

        // rst and start on the same edge
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'd5;
        divisor  = 16'd1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_start done", done, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("-7/2 s", 16'hFFF9, 16'h0002, 1'b1,
               16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 0);
        run_op("7/-2 s", 16'h0007, 16'hFFFE, 1'b1,
               16'hFFFD, 16'h0001, 1'b0, 1'b0, 17, 0);
        run_op("min/-1 s", 16'h8000, 16'hFFFF, 1'b1,
               16'h8000, 16'h0000, 1'b0, 1'b1, 17, 0);
        run_op("min/-1 u", 16'h8000, 16'hFFFF, 1'b0,
               16'h0000, 16'h8000, 1'b0, 1'b0, 17, 0);
        run_op("dbz s", 16'h8001, 16'h0000, 1'b1,
               16'hFFFF, 16'h8001, 1'b1, 1'b0, 1, 0);
`else
        run_op("-7/2 u", 16'hFFF9, 16'h0002, 1'b1,
               16'h7FFC, 16'h0001, 1'b0, 1'b0, 17, 0);
        run_op("min/-1 u", 16'h8000, 16'hFFFF, 1'b1,
               16'h0000, 16'h8000, 1'b0, 1'b0, 17, 0);
`endif

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 300));
            run_op("rand", ra, rb, 1'b0,
                   ra / rb, ra % rb, 1'b0, 1'b0, 17, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
